// File: rtl/alu_wb_stage_pkg.sv
// Shared processor package: opcode encodings, decode helpers, datapath widths
// and the write-back stage state encoding.
package alu_wb_stage_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ALU_MSB = DATA_W - 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LHB    = 4'b1010,
    OP_LLB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  function automatic logic op_writes_rf(input logic [OPC_W-1:0] op);
    return !(op == OP_SW || op == OP_B || op == OP_BR || op == OP_HLT);
  endfunction

  function automatic logic op_sets_znv(input logic [OPC_W-1:0] op);
    return (op == OP_ADD || op == OP_SUB);
  endfunction

  function automatic logic op_sets_z_only(input logic [OPC_W-1:0] op);
    return (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// Execute-to-write-back bus: instruction presentation in, registered results out.
interface alu_wb_stage_if;
  import alu_wb_stage_pkg::*;

  logic                in_valid;
  logic [OPC_W-1:0]    opcode;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_ovfl;
  logic [REG_W-1:0]    rd;
  logic                stall;
  logic                flush;

  logic                out_valid;
  logic [DATA_W-1:0]   wb_data;
  logic [REG_W-1:0]    wb_rd;
  logic                wb_we;
  logic                flag_z;
  logic                flag_v;
  logic                flag_n;
  logic                halted;
  logic [CNT_W-1:0]    retired_cnt;

  modport master (
    output in_valid, opcode, alu_out, alu_ovfl, rd, stall, flush,
    input  out_valid, wb_data, wb_rd, wb_we, flag_z, flag_v, flag_n, halted, retired_cnt
  );

  modport slave (
    input  in_valid, opcode, alu_out, alu_ovfl, rd, stall, flush,
    output out_valid, wb_data, wb_rd, wb_we, flag_z, flag_v, flag_n, halted, retired_cnt
  );

endinterface

// File: rtl/alu_wb_stage_flag_unit.sv
// Next-state computation for the architectural Z/V/N flags.
module flag_unit
  import alu_wb_stage_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_ovfl_i,
  input  logic              en_i,
  input  flags_t            flags_i,
  output flags_t            flags_o
);

  always_comb begin
    flags_o = flags_i;
    if (en_i) begin
      if (op_sets_znv(opcode_i)) begin
        flags_o.z = (alu_out_i == '0);
        flags_o.n = alu_out_i[ALU_MSB];
        flags_o.v = alu_ovfl_i;
      end else if (op_sets_z_only(opcode_i)) begin
        flags_o.z = (alu_out_i == '0);
      end
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Write-back stage: registers the ALU result, gates the RF write, keeps the
// flags and retire counter, and halts on HLT until reset.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_wb_stage_if.slave bus
);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [REG_W-1:0]    rd_q,    rd_d;
  logic                we_q,    we_d;
  flags_t              flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                accept;

  assign accept = (state_q == ST_RUN) && bus.in_valid && !bus.stall && !bus.flush;

  flag_unit u_flag_unit (
    .opcode_i   (bus.opcode),
    .alu_out_i  (bus.alu_out),
    .alu_ovfl_i (bus.alu_ovfl),
    .en_i       (accept),
    .flags_i    (flags_q),
    .flags_o    (flags_d)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    if (accept && bus.opcode == OP_HLT) begin
      state_d = ST_HALT;
    end

    // Halt and flush both drop the output slot; stall alone holds everything.
    if (state_q == ST_HALT || bus.flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.in_valid;
      we_d    = bus.in_valid && op_writes_rf(bus.opcode);
      if (accept) begin
        data_d = bus.alu_out;
        rd_d   = bus.rd;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.wb_data     = data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_we       = we_q;
  assign bus.flag_z      = flags_q.z;
  assign bus.flag_v      = flags_q.v;
  assign bus.flag_n      = flags_q.n;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: behavioural model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_alu_wb_stage;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  alu_wb_stage_if bus();

  alu_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit        m_live;
  bit        m_valid, m_we, m_z, m_v, m_n, m_halt;
  bit [15:0] m_data, m_cnt;
  bit [3:0]  m_rd;
  bit [15:0] writer_mask;

  initial begin
    writer_mask = 16'h4DFF; // opcodes 0-8, 10, 11, 14 write the register file
    m_live = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_valid = 0; m_we = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
      m_data = 0; m_cnt = 0; m_rd = 0;
    end else if (m_halt || bus.flush) begin
      m_valid = 0;
      m_we    = 0;
    end else if (bus.stall) begin
      // everything held
    end else if (!bus.in_valid) begin
      m_valid = 0;
      m_we    = 0;
    end else begin
      m_valid = 1;
      m_data  = bus.alu_out;
      m_rd    = bus.rd;
      m_we    = writer_mask[bus.opcode];
      m_cnt   = m_cnt + 16'd1;
      case (bus.opcode)
        4'd0, 4'd1: begin
          m_z = (bus.alu_out == 16'd0);
          m_n = bus.alu_out[15];
          m_v = bus.alu_ovfl;
        end
        4'd2, 4'd4, 4'd5, 4'd6: m_z = (bus.alu_out == 16'd0);
        default: ;
      endcase
      if (bus.opcode == 4'd15) m_halt = 1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
      check("cmp_wb_data",   bus.wb_data, m_data);
      check("cmp_wb_rd",     {12'd0, bus.wb_rd}, {12'd0, m_rd});
      check("cmp_wb_we",     {15'd0, bus.wb_we}, {15'd0, m_valid & m_we});
      check("cmp_flags",     {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {13'd0, m_z, m_v, m_n});
      check("cmp_halted",    {15'd0, bus.halted}, {15'd0, m_halt});
      check("cmp_retired",   bus.retired_cnt, m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] d,
                       input logic ov, input logic [3:0] r, input logic s, input logic f);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.alu_out  = d;
    bus.alu_ovfl = ov;
    bus.rd       = r;
    bus.stall    = s;
    bus.flush    = f;
  endtask

  task automatic expect_all(input string name, input logic ov, input logic [15:0] d,
                            input logic we, input logic z, input logic v, input logic n,
                            input logic h, input logic [15:0] cnt);
    check({name, "_valid"},  {15'd0, bus.out_valid}, {15'd0, ov});
    check({name, "_data"},   bus.wb_data, d);
    check({name, "_we"},     {15'd0, bus.wb_we}, {15'd0, we});
    check({name, "_zvn"},    {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {13'd0, z, v, n});
    check({name, "_halted"}, {15'd0, bus.halted}, {15'd0, h});
    check({name, "_cnt"},    bus.retired_cnt, cnt);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1;
    drive(1, 4'd0, 16'h1234, 0, 4'd1, 0, 0);
    repeat (2) @(negedge clk);
    expect_all("reset", 0, 16'h0000, 0, 0, 0, 0, 0, 16'd0);
    check("reset_rd", {12'd0, bus.wb_rd}, 16'd0);

    rst = 1'b0;
    drive(1, 4'd0, 16'h8000, 1, 4'd3, 0, 0);       // ADD
    @(negedge clk);
    expect_all("add", 1, 16'h8000, 1, 0, 1, 1, 0, 16'd1);
    check("add_rd", {12'd0, bus.wb_rd}, 16'd3);

    drive(1, 4'd3, 16'h0000, 0, 4'd4, 0, 0);       // RED
    @(negedge clk);
    expect_all("red", 1, 16'h0000, 1, 0, 1, 1, 0, 16'd2);

    drive(1, 4'd2, 16'h0000, 0, 4'd5, 1, 0);       // XOR under stall
    @(negedge clk);
    expect_all("stall1", 1, 16'h0000, 1, 0, 1, 1, 0, 16'd2);
    check("stall1_rd", {12'd0, bus.wb_rd}, 16'd4);
    @(negedge clk);
    expect_all("stall2", 1, 16'h0000, 1, 0, 1, 1, 0, 16'd2);
    bus.stall = 1'b0;
    @(negedge clk);
    expect_all("xor", 1, 16'h0000, 1, 1, 1, 1, 0, 16'd3);
    check("xor_rd", {12'd0, bus.wb_rd}, 16'd5);

    drive(1, 4'd1, 16'h0001, 0, 4'd6, 1, 1);       // SUB with stall+flush
    @(negedge clk);
    check("flush_valid", {15'd0, bus.out_valid}, 16'd0);
    check("flush_cnt", bus.retired_cnt, 16'd3);
    check("flush_flags", {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, 16'b111);

    drive(0, 4'd0, 16'h0, 0, 4'd0, 0, 0);
    @(negedge clk);
    check("idle_valid", {15'd0, bus.out_valid}, 16'd0);

    for (int unsigned i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom), 4'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
      @(negedge clk);
    end

    rst = 1'b1;
    drive(0, 4'd0, 16'h0, 0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 65535; i++) begin
      drive(1, 4'($urandom_range(0, 14)), 16'($urandom), 1'($urandom), 4'($urandom), 0, 0);
      @(negedge clk);
    end
    check("cnt_ffff", bus.retired_cnt, 16'hFFFF);
    drive(1, 4'd2, 16'h0042, 0, 4'd7, 0, 0);
    @(negedge clk);
    check("cnt_wrap", bus.retired_cnt, 16'h0000);
    check("wrap_data", bus.wb_data, 16'h0042);

    drive(1, 4'd15, 16'h0000, 0, 4'd0, 0, 0);      // HLT
    @(negedge clk);
    check("hlt_valid", {15'd0, bus.out_valid}, 16'd1);
    check("hlt_we", {15'd0, bus.wb_we}, 16'd0);
    check("hlt_halted", {15'd0, bus.halted}, 16'd1);
    check("hlt_cnt", bus.retired_cnt, 16'd1);

    drive(1, 4'd0, 16'h5555, 0, 4'd2, 0, 0);       // ADD while halted
    @(negedge clk);
    check("halt_valid", {15'd0, bus.out_valid}, 16'd0);
    check("halt_halted", {15'd0, bus.halted}, 16'd1);
    check("halt_cnt", bus.retired_cnt, 16'd1);
    check("halt_we", {15'd0, bus.wb_we}, 16'd0);

    rst = 1'b1;                                     // ADD still presented
    @(negedge clk);
    expect_all("rst_halt", 0, 16'h0000, 0, 0, 0, 0, 0, 16'd0);
    check("rst_rd", {12'd0, bus.wb_rd}, 16'd0);

    rst = 1'b0;
    @(negedge clk);
    expect_all("run_again", 1, 16'h5555, 1, 0, 0, 0, 0, 16'd1);

    drive(0, 4'd0, 16'h0, 0, 4'd0, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the execute stage presents an instruction this cycle.
- opcode  input  4  opcode of the presented instruction.
- alu_out  input  16  ALU result, including the RED reduction sum and the PADDSB result.
- alu_ovfl  input  1  signed overflow from the ADD/SUB datapath.
- rd  input  4  destination register index.
- stall  input  1  hold all registered state this cycle.
- flush  input  1  squash the presented instruction.
- out_valid  output  1  the registered instruction is valid.
- wb_data  output  16  registered write-back data.
- wb_rd  output  4  registered destination index.
- wb_we  output  1  register-file write enable (already gated by out_valid).
- flag_z, flag_v, flag_n  output  1 each  architectural Z, V and N flags.
- halted  output  1  the processor has retired HLT.
- retired_cnt  output  16  count of accepted instructions.

Function
REQ-002 An instruction SHALL be accepted on a rising edge only when in_valid=1, stall=0, flush=0 and the state is RUN.
REQ-003 Latency SHALL be one cycle: on the edge after acceptance, out_valid=1 and wb_data=alu_out, wb_rd=rd.
REQ-004 With stall=1 and flush=0, every register, including the flags and the counter, SHALL hold its value.
REQ-005 With flush=1, out_valid SHALL become 0 on the next edge, and the flags and counter SHALL be unchanged; flush wins over stall.
REQ-006 With in_valid=0 and no stall, out_valid SHALL become 0 on the next edge.
REQ-007 wb_we SHALL be out_valid AND (opcode in 0000-1000, 1010, 1011 or 1110); SW (1001), B (1100), BR (1101) and HLT (1111) SHALL NOT write.
REQ-008 Flag updates on acceptance SHALL follow these rules.
- ADD (0000) and SUB (0001): Z=(alu_out==0), N=alu_out[15], V=alu_ovfl.
- XOR (0010), SLL (0100), SRA (0101) and ROR (0110): Z=(alu_out==0); N and V are held.
- All other opcodes, including RED (0011) and PADDSB (0111): all flags are held.
REQ-009 Updated flags SHALL be visible on the outputs in the cycle after acceptance; the flags are not bypassed.
REQ-010 retired_cnt SHALL increment by 1 per accepted instruction, HLT included, and SHALL wrap from 0xFFFF to 0x0000.
REQ-011 The state machine SHALL have two states, RUN and HALT.
- RUN goes to HALT on acceptance of HLT (1111).
- HALT is left only by rst.
REQ-012 In HALT, halted=1, inputs SHALL be ignored, and out_valid=0 from the cycle after the HLT edge onward; HLT itself produces out_valid=1 with wb_we=0.
REQ-013 No combinational path SHALL exist from the inputs to any output.

Reset
REQ-014 While rst=1 at a clock edge, all of the following SHALL be 0 on the next cycle: out_valid, wb_data, wb_rd, wb_we, flags, halted and retired_cnt; state SHALL be RUN.
REQ-015 rst SHALL take priority over stall, flush and in_valid, including for an instruction presented in the same cycle.

Structure
REQ-016 The opcode constants (4-bit) and the RUN/HALT state encoding SHALL live in the shared processor package, alongside the decode and ALU constants.
REQ-017 The Z/V/N update logic SHALL be one sub-module, flag_unit, taking opcode, alu_out, alu_ovfl, an enable and the current flags, and returning the next flags.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- ADD with alu_out=0x8000 and alu_ovfl=1, accepted -> next cycle N=1, Z=0, V=1, wb_we=1, wb_data=0x8000.
- RED with alu_out=0x0000 after the previous ADD -> flags unchanged (N=1, V=1, Z=0), wb_we=1, wb_data=0x0000.
- XOR with alu_out=0 while stall=1 for 2 cycles, then stall=0 -> flags and outputs held for 2 cycles, then Z=1 with N and V held.
- SUB presented with stall=1 and flush=1 together -> out_valid=0 and retired_cnt unchanged.
- retired_cnt preset to 0xFFFF by 65535 accepts, then one accept -> 0x0000.
- HLT accepted, then ADD presented -> halted=1, the ADD is ignored and out_valid=0; rst then returns state to RUN with all outputs 0.
